// File: rtl/gnpu_cop_pkg.sv
// Purpose: shared encodings, decoded-op enum and issue-slot layout for the coprocessor dispatcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`ifndef COP_INST_WIDTH
`define COP_INST_WIDTH 32
`endif
`ifndef COP_REG_WIDTH
`define COP_REG_WIDTH 64
`endif

package gnpu_cop_pkg;

    localparam int COP_INST_W = `COP_INST_WIDTH;
    localparam int COP_REG_W  = `COP_REG_WIDTH;

    // Custom-1 style opcode shared by every coprocessor instruction
    localparam logic [6:0] OPC_COP = 7'b0101011;

    localparam logic [2:0] F3_FENCE      = 3'b000;
    localparam logic [2:0] F3_PRELOADC   = 3'b001;
    localparam logic [2:0] F3_TMMA       = 3'b010;
    localparam logic [2:0] F3_POSTSTOREC = 3'b011;
    localparam logic [2:0] F3_PRELOADA   = 3'b100;
    localparam logic [2:0] F3_PERF       = 3'b111;

    typedef enum logic [2:0] {
        OP_FENCE,
        OP_PRELOADC,
        OP_PRELOADA,
        OP_TMMA,
        OP_POSTSTOREC,
        OP_PERF,
        OP_ILLEGAL
    } op_e;

    // One accepted instruction waiting to issue
    typedef struct packed {
        op_e                  op;
        logic [2:0]           funct3;
        logic [COP_REG_W-1:0] rs1;
        logic [COP_REG_W-1:0] rs2;
        logic [COP_REG_W-1:0] rs3;
    } slot_t;

endpackage

// File: rtl/gnpu_cop_dispatch_if.sv
// Purpose: bundles the CPU request/response and unit command/done signals of the dispatcher.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on request, response and each unit command; done is a pulse.
interface gnpu_cop_dispatch_if;
    import gnpu_cop_pkg::*;

    logic                  req_vld;
    logic                  req_rdy;
    logic [COP_INST_W-1:0] req_insn;
    logic [COP_REG_W-1:0]  req_rs1;
    logic [COP_REG_W-1:0]  req_rs2;
    logic [COP_REG_W-1:0]  req_rs3;
    logic                  resp_vld;
    logic                  resp_rdy;
    logic [COP_REG_W-1:0]  resp_data;
    logic                  ld_cmd_vld;
    logic                  ld_cmd_rdy;
    logic                  ld_cmd_isa;
    logic                  ld_done;
    logic                  mac_cmd_vld;
    logic                  mac_cmd_rdy;
    logic                  mac_done;
    logic                  st_cmd_vld;
    logic                  st_cmd_rdy;
    logic                  st_done;
    logic [COP_REG_W-1:0]  cmd_rs1;
    logic [COP_REG_W-1:0]  cmd_rs2;
    logic [COP_REG_W-1:0]  cmd_rs3;

    // CPU and execution units: drive requests, response ready, unit ready and done
    modport master (
        output req_vld, req_insn, req_rs1, req_rs2, req_rs3, resp_rdy,
               ld_cmd_rdy, ld_done, mac_cmd_rdy, mac_done, st_cmd_rdy, st_done,
        input  req_rdy, resp_vld, resp_data, ld_cmd_vld, ld_cmd_isa,
               mac_cmd_vld, st_cmd_vld, cmd_rs1, cmd_rs2, cmd_rs3
    );

    // Dispatcher side
    modport slave (
        input  req_vld, req_insn, req_rs1, req_rs2, req_rs3, resp_rdy,
               ld_cmd_rdy, ld_done, mac_cmd_rdy, mac_done, st_cmd_rdy, st_done,
        output req_rdy, resp_vld, resp_data, ld_cmd_vld, ld_cmd_isa,
               mac_cmd_vld, st_cmd_vld, cmd_rs1, cmd_rs2, cmd_rs3
    );
endinterface

// File: rtl/gnpu_cop_decode.sv
// Purpose: classify a coprocessor instruction word into an op_e (perf read legal only with GNPU_COP_PERF_EN).
// Latency: purely combinational.
// Backpressure: none.
module gnpu_cop_decode
    import gnpu_cop_pkg::*;
(
    input  logic [COP_INST_W-1:0] insn_i,
    output op_e                   op_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_insn_bits;

    assign opcode           = insn_i[6:0];
    assign funct3           = insn_i[14:12];
    assign unused_insn_bits = ^{insn_i[COP_INST_W-1:15], insn_i[11:7]};

    // Map opcode/funct3 to an operation; anything unrecognised is illegal
    always_comb begin
        op_o = OP_ILLEGAL;
        if (opcode == OPC_COP) begin
            case (funct3)
                F3_FENCE:      op_o = OP_FENCE;
                F3_PRELOADC:   op_o = OP_PRELOADC;
                F3_PRELOADA:   op_o = OP_PRELOADA;
                F3_TMMA:       op_o = OP_TMMA;
                F3_POSTSTOREC: op_o = OP_POSTSTOREC;
`ifdef GNPU_COP_PERF_EN
                F3_PERF:       op_o = OP_PERF;
`else
                F3_PERF:       op_o = OP_ILLEGAL;
`endif
                default:       op_o = OP_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/gnpu_cop_dispatch.sv
// Purpose: one-slot coprocessor dispatcher with per-unit busy hazards; GNPU_COP_PERF_EN adds a tmma counter read.
// Latency: request accepted in N, earliest issue N+1, response valid N+2; slot refills on the issue cycle.
// Backpressure: issue stalls on unit busy, unit cmd_rdy low, or an undrained response; req_rdy drops when the slot is stuck.
module gnpu_cop_dispatch
    import gnpu_cop_pkg::*;
#(
    parameter int RESP_ERR_BIT = 8,
    parameter int PERF_CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cpu_tpu_req_vld_i,
    output logic                       cpu_tpu_req_rdy_o,
    input  logic [`COP_INST_WIDTH-1:0] cpu_tpu_req_insn_i,
    input  logic [`COP_REG_WIDTH-1:0]  cpu_tpu_req_rs1_data_i,
    input  logic [`COP_REG_WIDTH-1:0]  cpu_tpu_req_rs2_data_i,
    input  logic [`COP_REG_WIDTH-1:0]  cpu_tpu_req_rs3_data_i,
    output logic                       cpu_tpu_resp_vld_o,
    input  logic                       cpu_tpu_resp_rdy_i,
    output logic [`COP_REG_WIDTH-1:0]  cpu_tpu_resp_data_o,
    output logic                       ld_cmd_vld_o,
    input  logic                       ld_cmd_rdy_i,
    output logic                       ld_cmd_isa_o,
    input  logic                       ld_done_i,
    output logic                       mac_cmd_vld_o,
    input  logic                       mac_cmd_rdy_i,
    input  logic                       mac_done_i,
    output logic                       st_cmd_vld_o,
    input  logic                       st_cmd_rdy_i,
    input  logic                       st_done_i,
    output logic [`COP_REG_WIDTH-1:0]  cmd_rs1_o,
    output logic [`COP_REG_WIDTH-1:0]  cmd_rs2_o,
    output logic [`COP_REG_WIDTH-1:0]  cmd_rs3_o
);

    slot_t                slot_q, slot_d;
    logic                 slot_vld_q, slot_vld_d;
    logic                 ld_busy_q, ld_busy_d;
    logic                 mac_busy_q, mac_busy_d;
    logic                 st_busy_q, st_busy_d;
    logic                 resp_vld_q, resp_vld_d;
    logic [COP_REG_W-1:0] resp_data_q, resp_data_d;
    logic [COP_REG_W-1:0] resp_word;

    op_e  req_op;
    logic req_hs;
    logic resp_free;
    logic hazard_ok;
    logic unit_rdy;
    logic issue_ok;
    logic slot_fire;
    logic is_preload, is_tmma, is_store;
    logic ld_cmd_vld, mac_cmd_vld, st_cmd_vld;
    logic ld_hs, mac_hs, st_hs;

`ifdef GNPU_COP_PERF_EN
    logic [PERF_CNT_W-1:0] perf_cnt_q, perf_cnt_d;
`else
    localparam int unused_perf_cnt_w = PERF_CNT_W;
`endif

    gnpu_cop_decode u_decode (
        .insn_i (cpu_tpu_req_insn_i),
        .op_o   (req_op)
    );

    assign is_preload = (slot_q.op == OP_PRELOADC) || (slot_q.op == OP_PRELOADA);
    assign is_tmma    = (slot_q.op == OP_TMMA);
    assign is_store   = (slot_q.op == OP_POSTSTOREC);

    // The response register can take a new word if it is empty or being drained this cycle
    assign resp_free = !resp_vld_q || cpu_tpu_resp_rdy_i;

    // Hazard rule and target-unit ready for the op sitting in the slot
    always_comb begin
        hazard_ok = 1'b1;
        unit_rdy  = 1'b1;
        case (slot_q.op)
            OP_PRELOADC, OP_PRELOADA: begin
                hazard_ok = !mac_busy_q && !ld_busy_q;
                unit_rdy  = ld_cmd_rdy_i;
            end
            OP_TMMA: begin
                hazard_ok = !ld_busy_q && !mac_busy_q;
                unit_rdy  = mac_cmd_rdy_i;
            end
            OP_POSTSTOREC: begin
                hazard_ok = !mac_busy_q && !st_busy_q;
                unit_rdy  = st_cmd_rdy_i;
            end
            OP_FENCE: begin
                hazard_ok = !ld_busy_q && !mac_busy_q && !st_busy_q;
            end
            default: begin
                hazard_ok = 1'b1;
                unit_rdy  = 1'b1;
            end
        endcase
    end

    // cmd_vld excludes cmd_rdy so a unit may wait for valid before raising ready
    assign issue_ok    = slot_vld_q && resp_free && hazard_ok;
    assign ld_cmd_vld  = issue_ok && is_preload;
    assign mac_cmd_vld = issue_ok && is_tmma;
    assign st_cmd_vld  = issue_ok && is_store;
    assign ld_hs       = ld_cmd_vld && ld_cmd_rdy_i;
    assign mac_hs      = mac_cmd_vld && mac_cmd_rdy_i;
    assign st_hs       = st_cmd_vld && st_cmd_rdy_i;
    assign slot_fire   = issue_ok && unit_rdy;
    assign req_hs      = cpu_tpu_req_vld_i && cpu_tpu_req_rdy_o;

    assign cpu_tpu_req_rdy_o   = !slot_vld_q || slot_fire;
    assign cpu_tpu_resp_vld_o  = resp_vld_q;
    assign cpu_tpu_resp_data_o = resp_data_q;
    assign ld_cmd_vld_o        = ld_cmd_vld;
    assign mac_cmd_vld_o       = mac_cmd_vld;
    assign st_cmd_vld_o        = st_cmd_vld;
    assign ld_cmd_isa_o        = (slot_q.op == OP_PRELOADA);
    assign cmd_rs1_o           = slot_q.rs1;
    assign cmd_rs2_o           = slot_q.rs2;
    assign cmd_rs3_o           = slot_q.rs3;

    // Response word for the issuing op: funct3 plus error flag, or the counter for a perf read
    always_comb begin
        resp_word               = '0;
        resp_word[2:0]          = slot_q.funct3;
        resp_word[RESP_ERR_BIT] = (slot_q.op == OP_ILLEGAL);
`ifdef GNPU_COP_PERF_EN
        if (slot_q.op == OP_PERF) begin
            resp_word                 = '0;
            resp_word[PERF_CNT_W-1:0] = perf_cnt_q;
        end
`endif
    end

    // Next state for slot, busy bits, response register and counter
    always_comb begin
        slot_d      = slot_q;
        slot_vld_d  = slot_vld_q;
        resp_vld_d  = resp_vld_q;
        resp_data_d = resp_data_q;

        if (req_hs) begin
            slot_vld_d    = 1'b1;
            slot_d.op     = req_op;
            slot_d.funct3 = cpu_tpu_req_insn_i[14:12];
            slot_d.rs1    = cpu_tpu_req_rs1_data_i;
            slot_d.rs2    = cpu_tpu_req_rs2_data_i;
            slot_d.rs3    = cpu_tpu_req_rs3_data_i;
        end else if (slot_fire) begin
            slot_vld_d = 1'b0;
        end

        // A done from an idle unit leaves busy low; set wins since set implies idle
        ld_busy_d  = ld_hs  ? 1'b1 : (ld_done_i  ? 1'b0 : ld_busy_q);
        mac_busy_d = mac_hs ? 1'b1 : (mac_done_i ? 1'b0 : mac_busy_q);
        st_busy_d  = st_hs  ? 1'b1 : (st_done_i  ? 1'b0 : st_busy_q);

        if (resp_vld_q && cpu_tpu_resp_rdy_i) begin
            resp_vld_d = 1'b0;
        end
        if (slot_fire) begin
            resp_vld_d  = 1'b1;
            resp_data_d = resp_word;
        end

`ifdef GNPU_COP_PERF_EN
        perf_cnt_d = perf_cnt_q + (mac_hs ? PERF_CNT_W'(1) : PERF_CNT_W'(0));
`endif
    end

    // State registers; reset discards any in-flight unit state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= '0;
            slot_vld_q  <= 1'b0;
            ld_busy_q   <= 1'b0;
            mac_busy_q  <= 1'b0;
            st_busy_q   <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
`ifdef GNPU_COP_PERF_EN
            perf_cnt_q  <= '0;
`endif
        end else begin
            slot_q      <= slot_d;
            slot_vld_q  <= slot_vld_d;
            ld_busy_q   <= ld_busy_d;
            mac_busy_q  <= mac_busy_d;
            st_busy_q   <= st_busy_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
`ifdef GNPU_COP_PERF_EN
            perf_cnt_q  <= perf_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_gnpu_cop_dispatch.sv
// Purpose: self-checking bench for gnpu_cop_dispatch (vector table, scoreboard, corner-case sequences).
// Latency: n/a.
// Backpressure: bench models units with programmable done hold and drives resp_rdy stalls.
module tb_gnpu_cop_dispatch;
    import gnpu_cop_pkg::*;

    localparam int RW = COP_REG_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gnpu_cop_dispatch_if bus ();

    gnpu_cop_dispatch #(.RESP_ERR_BIT(8), .PERF_CNT_W(32)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .cpu_tpu_req_vld_i      (bus.req_vld),
        .cpu_tpu_req_rdy_o      (bus.req_rdy),
        .cpu_tpu_req_insn_i     (bus.req_insn),
        .cpu_tpu_req_rs1_data_i (bus.req_rs1),
        .cpu_tpu_req_rs2_data_i (bus.req_rs2),
        .cpu_tpu_req_rs3_data_i (bus.req_rs3),
        .cpu_tpu_resp_vld_o     (bus.resp_vld),
        .cpu_tpu_resp_rdy_i     (bus.resp_rdy),
        .cpu_tpu_resp_data_o    (bus.resp_data),
        .ld_cmd_vld_o           (bus.ld_cmd_vld),
        .ld_cmd_rdy_i           (bus.ld_cmd_rdy),
        .ld_cmd_isa_o           (bus.ld_cmd_isa),
        .ld_done_i              (bus.ld_done),
        .mac_cmd_vld_o          (bus.mac_cmd_vld),
        .mac_cmd_rdy_i          (bus.mac_cmd_rdy),
        .mac_done_i             (bus.mac_done),
        .st_cmd_vld_o           (bus.st_cmd_vld),
        .st_cmd_rdy_i           (bus.st_cmd_rdy),
        .st_done_i              (bus.st_done),
        .cmd_rs1_o              (bus.cmd_rs1),
        .cmd_rs2_o              (bus.cmd_rs2),
        .cmd_rs3_o              (bus.cmd_rs3)
    );

    int errors = 0;
    int checks = 0;

    // Scoreboard: expected words pushed at request acceptance, actual words logged by the monitor
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] act_data [0:255];
    int            resp_cnt = 0;
    int            chk_idx  = 0;

    // Monitor / unit model state (written only by the monitor process)
    int            ld_hs = 0, mac_hs = 0, st_hs = 0, ld_vld_cyc = 0;
    logic          last_isa = 1'b0;
    logic [RW-1:0] last_rs1 = '0;
    logic [2:0]    done_v;
    logic [2:0]    pend;
    int            cnt [3];
    // Written only by the main sequence: keeps a unit's done pulse withheld
    logic [2:0]    hold = '0;

    assign bus.ld_done  = done_v[0];
    assign bus.mac_done = done_v[1];
    assign bus.st_done  = done_v[2];

    typedef struct {
        logic [6:0]    opc;
        logic [2:0]    f3;
        logic [RW-1:0] exp;
        int            d_ld;
        int            d_mac;
        int            d_st;
        logic          isa;
    } vec_t;
    vec_t vt [9];

    // Monitor and unit model: sample at negedge, emit done pulses just after posedge
    initial begin
        done_v = '0;
        pend   = '0;
        for (int u = 0; u < 3; u++) cnt[u] = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = '0;
            end else begin
                if (bus.resp_vld && bus.resp_rdy) begin
                    if (resp_cnt < 256) act_data[resp_cnt] = bus.resp_data;
                    resp_cnt++;
                end
                if (bus.ld_cmd_vld) ld_vld_cyc++;
                if (bus.ld_cmd_vld && bus.ld_cmd_rdy) begin
                    ld_hs++; last_isa = bus.ld_cmd_isa; last_rs1 = bus.cmd_rs1; pend[0] = 1'b1; cnt[0] = 2;
                end
                if (bus.mac_cmd_vld && bus.mac_cmd_rdy) begin
                    mac_hs++; last_rs1 = bus.cmd_rs1; pend[1] = 1'b1; cnt[1] = 2;
                end
                if (bus.st_cmd_vld && bus.st_cmd_rdy) begin
                    st_hs++; last_rs1 = bus.cmd_rs1; pend[2] = 1'b1; cnt[2] = 2;
                end
            end
            @(posedge clk);
            #1;
            for (int u = 0; u < 3; u++) begin
                done_v[u] = 1'b0;
                if (pend[u]) begin
                    if (cnt[u] > 0) cnt[u]--;
                    else if (!hold[u]) begin
                        done_v[u] = 1'b1;
                        pend[u]   = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [RW-1:0] rs1,
                        input logic [RW-1:0] exp);
        logic [COP_INST_W-1:0] insn;
        logic                  ok;
        ok           = 1'b0;
        insn         = COP_INST_W'($urandom);
        insn[6:0]    = opc;
        insn[14:12]  = f3;
        bus.req_vld  = 1'b1;
        bus.req_insn = insn;
        bus.req_rs1  = rs1;
        bus.req_rs2  = ~rs1;
        bus.req_rs3  = rs1 ^ RW'(64'h5a5a);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_rdy) ok = 1'b1;
        end
        check("req_accept", RW'(ok), RW'(1));
        if (ok) exp_q.push_back(exp);
        tick();
        bus.req_vld = 1'b0;
    endtask

    // Wait for every outstanding response, then compare in order against the scoreboard
    task automatic wait_drain();
        int target;
        int i;
        target = chk_idx + exp_q.size();
        i = 0;
        while (resp_cnt < target && i < 200) begin
            tick();
            i++;
        end
        check("resp_count", RW'(resp_cnt), RW'(target));
        while (chk_idx < resp_cnt) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_extra: got 0x%0h, expected no response", act_data[chk_idx]);
            end else begin
                check("resp_data", act_data[chk_idx], exp_q.pop_front());
            end
            chk_idx++;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && pend != 3'b000; i++) tick();
        repeat (3) tick();
    endtask

    initial begin
        int            b_ld, b_mac, b_st, b_vc;
        logic [RW-1:0] rs1;
        logic          seen;
        logic [RW-1:0] exp_perf;

        bus.req_vld     = 1'b0;
        bus.req_insn    = '0;
        bus.req_rs1     = '0;
        bus.req_rs2     = '0;
        bus.req_rs3     = '0;
        bus.resp_rdy    = 1'b1;
        bus.ld_cmd_rdy  = 1'b1;
        bus.mac_cmd_rdy = 1'b1;
        bus.st_cmd_rdy  = 1'b1;

        vt[0] = '{opc: OPC_COP,    f3: 3'b001, exp: RW'(12'h001), d_ld: 1, d_mac: 0, d_st: 0, isa: 1'b0};
        vt[1] = '{opc: OPC_COP,    f3: 3'b100, exp: RW'(12'h004), d_ld: 1, d_mac: 0, d_st: 0, isa: 1'b1};
        vt[2] = '{opc: OPC_COP,    f3: 3'b010, exp: RW'(12'h002), d_ld: 0, d_mac: 1, d_st: 0, isa: 1'b0};
        vt[3] = '{opc: OPC_COP,    f3: 3'b011, exp: RW'(12'h003), d_ld: 0, d_mac: 0, d_st: 1, isa: 1'b0};
        vt[4] = '{opc: OPC_COP,    f3: 3'b000, exp: RW'(12'h000), d_ld: 0, d_mac: 0, d_st: 0, isa: 1'b0};
        vt[5] = '{opc: OPC_COP,    f3: 3'b101, exp: RW'(12'h105), d_ld: 0, d_mac: 0, d_st: 0, isa: 1'b0};
        vt[6] = '{opc: OPC_COP,    f3: 3'b110, exp: RW'(12'h106), d_ld: 0, d_mac: 0, d_st: 0, isa: 1'b0};
        vt[7] = '{opc: 7'b0001011, f3: 3'b001, exp: RW'(12'h101), d_ld: 0, d_mac: 0, d_st: 0, isa: 1'b0};
        vt[8] = '{opc: 7'b1111111, f3: 3'b010, exp: RW'(12'h102), d_ld: 0, d_mac: 0, d_st: 0, isa: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_rdy", RW'(bus.req_rdy), RW'(1));
        check("rst_resp_vld", RW'(bus.resp_vld), RW'(0));
        check("rst_resp_data", bus.resp_data, RW'(0));
        check("rst_cmd_vld", RW'({bus.ld_cmd_vld, bus.mac_cmd_vld, bus.st_cmd_vld}), RW'(0));
        rst_n = 1'b1;
        tick();

        // Table of single instructions, each run to completion
        for (int i = 0; i < 9; i++) begin
            b_ld  = ld_hs;
            b_mac = mac_hs;
            b_st  = st_hs;
            b_vc  = ld_vld_cyc;
            rs1   = {$urandom, $urandom};
            send(vt[i].opc, vt[i].f3, rs1, vt[i].exp);
            wait_drain();
            wait_idle();
            check($sformatf("v%0d_ld_cmds", i), RW'(ld_hs - b_ld), RW'(vt[i].d_ld));
            check($sformatf("v%0d_mac_cmds", i), RW'(mac_hs - b_mac), RW'(vt[i].d_mac));
            check($sformatf("v%0d_st_cmds", i), RW'(st_hs - b_st), RW'(vt[i].d_st));
            if (vt[i].d_ld != 0) begin
                check($sformatf("v%0d_ld_isa", i), RW'(last_isa), RW'(vt[i].isa));
                check($sformatf("v%0d_ld_vld_cycles", i), RW'(ld_vld_cyc - b_vc), RW'(1));
            end
            if ((vt[i].d_ld + vt[i].d_mac + vt[i].d_st) != 0)
                check($sformatf("v%0d_cmd_rs1", i), last_rs1, rs1);
        end

        // tmma blocked behind a busy load until the cycle after ld_done
        @(negedge clk);
        hold[0] = 1'b1;
        tick();
        send(OPC_COP, 3'b001, RW'(64'h11), RW'(12'h001));
        wait_drain();
        send(OPC_COP, 3'b010, RW'(64'h22), RW'(12'h002));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("tmma_blocked_mac_vld", RW'(bus.mac_cmd_vld), RW'(0));
        end
        hold[0] = 1'b0;
        @(negedge clk);
        check("tmma_ld_done_cycle", RW'(bus.ld_done), RW'(1));
        check("tmma_mac_vld_on_done", RW'(bus.mac_cmd_vld), RW'(0));
        @(negedge clk);
        check("tmma_mac_vld_after_done", RW'(bus.mac_cmd_vld), RW'(1));
        wait_drain();
        wait_idle();

        // fence waits for the busy MAC, issues the cycle after mac_done
        @(negedge clk);
        hold[1] = 1'b1;
        tick();
        send(OPC_COP, 3'b010, RW'(64'h33), RW'(12'h002));
        wait_drain();
        send(OPC_COP, 3'b000, RW'(64'h44), RW'(12'h000));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("fence_no_resp", RW'(bus.resp_vld), RW'(0));
        end
        hold[1] = 1'b0;
        @(negedge clk);
        check("fence_mac_done_cycle", RW'(bus.mac_done), RW'(1));
        check("fence_resp_on_done", RW'(bus.resp_vld), RW'(0));
        @(negedge clk);
        check("fence_issue_after_done", RW'(bus.req_rdy), RW'(1));
        @(negedge clk);
        check("fence_resp_vld", RW'(bus.resp_vld), RW'(1));
        wait_drain();
        wait_idle();

        // Response backpressure: second request parks in the slot, req_rdy low until drain
        bus.resp_rdy = 1'b0;
        send(OPC_COP, 3'b100, RW'(64'h55), RW'(12'h004));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.resp_vld) seen = 1'b1;
        end
        check("bp_first_resp", RW'(seen), RW'(1));
        tick();
        send(OPC_COP, 3'b010, RW'(64'h66), RW'(12'h002));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_req_rdy_low", RW'(bus.req_rdy), RW'(0));
            check("bp_mac_vld_low", RW'(bus.mac_cmd_vld), RW'(0));
        end
        check("bp_resp_held", bus.resp_data, RW'(12'h004));
        tick();
        bus.resp_rdy = 1'b1;
        @(negedge clk);
        check("bp_issue_on_drain", RW'(bus.mac_cmd_vld), RW'(1));
        check("bp_req_rdy_on_drain", RW'(bus.req_rdy), RW'(1));
        wait_drain();
        wait_idle();

        // Asynchronous reset while a response is pending
        bus.resp_rdy = 1'b0;
        send(OPC_COP, 3'b000, RW'(64'h77), RW'(12'h000));
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.resp_vld) seen = 1'b1;
        end
        check("arst_resp_pending", RW'(seen), RW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_resp_vld", RW'(bus.resp_vld), RW'(0));
        check("arst_resp_data", bus.resp_data, RW'(0));
        check("arst_req_rdy", RW'(bus.req_rdy), RW'(1));
        exp_q.delete();
        bus.resp_rdy = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Counter read after three tmma since reset (illegal when the counter is not built)
        for (int k = 0; k < 3; k++) begin
            send(OPC_COP, 3'b010, RW'(k), RW'(12'h002));
            wait_drain();
            wait_idle();
        end
`ifdef GNPU_COP_PERF_EN
        exp_perf = RW'(3);
`else
        exp_perf = RW'(12'h107);
`endif
        send(OPC_COP, 3'b111, RW'(64'h88), exp_perf);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/gnpu_cop_dispatch.md
GNPU_COP_DISPATCH -- requirements
Module: gnpu_cop_dispatch

Interface
REQ-001 SHALL have parameter RESP_ERR_BIT, default 8, bit index of the error flag in resp data.
REQ-002 SHALL have parameter PERF_CNT_W, default 32, width of the tmma issue counter (must be ≤ `COP_REG_WIDTH).
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_tpu_req_vld_i  in  1  request valid.
- cpu_tpu_req_rdy_o  out  1  request ready.
- cpu_tpu_req_insn_i  in  `COP_INST_WIDTH  instruction.
- cpu_tpu_req_rs1_data_i / rs2 / rs3  in  `COP_REG_WIDTH  operands.
- cpu_tpu_resp_vld_o  out  1  response valid.
- cpu_tpu_resp_rdy_i  in  1  response ready.
- cpu_tpu_resp_data_o  out  `COP_REG_WIDTH  response data.
- ld_cmd_vld_o / ld_cmd_rdy_i / ld_cmd_isa_o  out/in/out  1/1/1  load command; isa=1 preloada, 0 preloadc.
- ld_done_i  in  1  load completion pulse.
- mac_cmd_vld_o / mac_cmd_rdy_i / mac_done_i  out/in/in  1/1/1  tmma command and completion.
- st_cmd_vld_o / st_cmd_rdy_i / st_done_i  out/in/in  1/1/1  poststorec command and completion.
- cmd_rs1_o, cmd_rs2_o, cmd_rs3_o  out  `COP_REG_WIDTH  operands of the issuing command, shared by all units.

Function
REQ-004 SHALL decode opcode 7'b0101011 with funct3 insn[14:12]: 001 preloadc, 100 preloada, 010 tmma, 011 poststorec, 000 fence; any other opcode/funct3 is illegal.
REQ-005 SHALL hold one instruction in an issue slot; cpu_tpu_req_rdy_o = !slot_vld || slot_fire, so the slot refills in the same cycle it issues.
REQ-006 SHALL issue the slot (slot_fire) only when the response register is empty or draining this cycle, the hazard rule holds, and the target unit's cmd_rdy is high.
REQ-007 Hazards SHALL use registered per-unit busy bits:
- preload waits for !mac_busy and !ld_busy.
- tmma waits for !ld_busy and !mac_busy.
- poststorec waits for !mac_busy and !st_busy.
- fence waits for all three units idle, sends no command.
- illegal instructions issue with no hazard check and no command.
REQ-008 Busy SHALL set on the command handshake and clear on the done pulse; a done in cycle N allows issue in cycle N+1, not N.
REQ-009 cmd_vld SHALL be high only when the slot is valid and the hazard rule holds, with operands driven from the slot; cmd_vld SHALL not depend combinationally on cmd_rdy.
REQ-010 On slot_fire the response register SHALL load data = zero-extended funct3 in [2:0], bit RESP_ERR_BIT = 1 if illegal, all other bits 0; resp_vld holds until cpu_tpu_resp_rdy_i.
REQ-011 Exactly one response SHALL be produced per accepted request, in acceptance order.
REQ-012 A done pulse from an idle unit SHALL be ignored.

Reset
REQ-013 On rst_n low (asynchronous) the block SHALL clear the slot, busy bits, counter and response register: req_rdy=1, resp_vld=0, resp_data=0, all cmd_vld=0.
REQ-014 After reset the block SHALL drop any in-flight unit state and SHALL not expect done pulses for commands issued before reset.

Configuration
REQ-015 With macro GNPU_COP_PERF_EN defined:
- funct3 111 SHALL be legal and issue with no hazard check.
- Its response data SHALL be the PERF_CNT_W-bit count of tmma handshakes, zero-extended.
- The counter wraps at 2^PERF_CNT_W.
REQ-016 Without GNPU_COP_PERF_EN, funct3 111 SHALL be illegal and no counter SHALL be built.

Structure
REQ-017 The opcode, funct3 encodings, an op_e enum and the decoded slot struct SHALL live in package gnpu_cop_pkg.
REQ-018 Decode SHALL be a combinational sub-module gnpu_cop_decode (insn in, op_e out).
REQ-019 The FSM, busy bits and response register SHALL stay in gnpu_cop_dispatch.

Verification
REQ-020 The bench SHALL cover these scenarios:
- preloadc, with ld_cmd_rdy=1 and resp_rdy=1 -> ld_cmd_vld one cycle with isa=0, resp_data=0x1.
- tmma sent while ld_busy -> mac_cmd_vld stays 0 until the cycle after ld_done, then resp_data=0x2.
- fence while mac busy -> no response until the cycle after mac_done, then resp_data=0x0.
- insn funct3=101 -> immediate response with data 0x105 (RESP_ERR_BIT=8), no cmd_vld.
- resp_rdy=0 for 5 cycles after a response -> second request accepted into the slot but not issued; req_rdy low until the response drains.
- GNPU_COP_PERF_EN with 3 tmma then funct3 111 -> resp_data=3; without the macro -> 0x107.
